execute_stage_mc: RTL and testbench
===================================

// Module: execute_stage_mc
// PURPOSE
//  Parametrised EX stage with integrated EX/MEM pipeline register for the MIPS core. Single-cycle ALU ops
//  plus iterative MULT/MULTU into HI/LO; MFHI/MFLO read them back. Adds valid/stall/flush pipeline control.
//  Sits between ID/EX latch and MEM stage; stall_out holds upstream stages during multiply or MEM stall.
// PARAMETERS
//  DATA_W    32  datapath width (>=8)
//  REG_AW    5   register-address width
//  BR_SHIFT  2   left shift applied to s_extend in branch-target adder
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        asynchronous active-low reset
//  in_valid        in   1        ID/EX holds a real instruction
//  mem_stall       in   1        MEM stage cannot accept; hold EX/MEM register
//  flush           in   1        squash in-flight EX work (branch mispredict)
//  ctlwb_in        in   2        WB control bits, passed through
//  ctlm_in         in   2        MEM control bits, passed through
//  npc             in   DATA_W   PC+4 of instruction
//  rdata1, rdata2  in   DATA_W   register operands A, B
//  s_extend        in   DATA_W   sign-extended immediate
//  instr_2016      in   REG_AW   rt field
//  instr_1511      in   REG_AW   rd field
//  alu_op          in   2        00 add, 01 sub, 10 R-type (funct), 11 reserved
//  funct           in   6        R-type function code
//  alusrc          in   1        1: B = s_extend, 0: B = rdata2
//  regdst          in   1        1: dest = rd, 0: dest = rt
//  out_valid       out  1        EX/MEM holds a real instruction
//  ctlwb_out       out  2        registered WB control
//  ctlm_out        out  2        registered MEM control
//  adder_out       out  DATA_W   registered npc + (s_extend << BR_SHIFT), mod 2^DATA_W
//  alu_result_out  out  DATA_W   registered ALU/HI/LO result
//  zero_out        out  1        registered (alu_result == 0)
//  rdata2_out      out  DATA_W   registered rdata2 (store data)
//  muxout_out      out  REG_AW   registered destination register
//  stall_out       out  1        combinational: (state==MUL) | mem_stall
// BEHAVIOUR
//  Reset: all outputs, HI, LO, counter = 0; state = IDLE. Async assert, sync release.
//  accept = in_valid & ~stall_out & ~flush. Upstream holds inputs while stall_out=1.
//  R-type: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed), 011000 MULT,
//   011001 MULTU, 010000 MFHI, 010010 MFLO; other funct -> result 0. alu_op 11 -> result 0.
//  Add/sub wrap mod 2^DATA_W, no overflow trap. ALU ops: latency 1 edge into EX/MEM.
//  On accept: EX/MEM loads all fields, out_valid=1. No accept and no stall: out_valid=0, ctl outputs=0.
//  mem_stall=1 (no flush): every EX/MEM output holds; FSM keeps counting.
//  MULT/MULTU on accept: EX/MEM loads with ctlwb_out=ctlm_out=0 (no GPR write), state IDLE->MUL,
//   operands latched (MULT: magnitudes + result sign), counter=DATA_W.
//  MUL: one shift-add step per cycle, counter decrements; on edge where counter 1->0: HI:LO <= product
//   (negated if signed result negative), state->IDLE. Exactly DATA_W cycles with stall_out=1.
//  MFHI/MFLO accepted in cycle after MUL ends see new HI/LO.
//  flush (highest priority after reset): next edge out_valid=0, ctl outputs=0, MUL aborted to IDLE,
//   HI/LO unchanged; data outputs don't-care. flush with mem_stall: flush wins.
//  Reset mid-MUL: immediate IDLE, HI/LO=0.
// TESTING
//  T1 rdata1=10 rdata2=20 alu_op=10 funct=100000 alusrc=0 regdst=1 instr_1511=10 npc=100 s_extend=4
//     -> alu_result_out=30, muxout_out=10, adder_out=116, out_valid=1 after 1 edge.
//  T2 alusrc=1 regdst=0 instr_2016=5 alu_op=00 -> result 14, muxout_out=5; alu_op=01 rdata1=rdata2=7
//     alusrc=0 -> result 0, zero_out=1; 10-20 -> 0xFFFFFFF6, zero_out=0.
//  T3 MULT rdata1=-7 rdata2=3 -> stall_out high 32 cycles, then MFLO -> 0xFFFFFFEB, MFHI -> 0xFFFFFFFF;
//     MULT out_valid=1 with ctlwb_out=0.
//  T4 MULTU 0xFFFFFFFF x 2 -> HI=1, LO=0xFFFFFFFE; slt -1,1 -> 1.
//  T5 mem_stall=1 for 3 cycles after T1 -> outputs frozen at 30; during MUL counter still ends on time.
//  T6 flush at MUL cycle 10 -> stall_out=0 next cycle, HI/LO keep prior values; rst_n low mid-MUL
//     -> all outputs 0 immediately, HI=LO=0.

Source files
------------

// File: rtl/execute_stage_mc.sv
// MIPS execute stage with integrated EX/MEM register: single-cycle ALU, iterative MULT/MULTU into HI/LO,
// and valid/stall/flush pipeline control.
//
// state | meaning
// IDLE  | ALU ops flow through; MULT/MULTU may start
// MUL   | one shift-add step per cycle, upstream held via stall_out
module execute_stage_mc #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mem_stall,
    input  logic              flush,
    input  logic [1:0]        ctlwb_in,
    input  logic [1:0]        ctlm_in,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] s_extend,
    input  logic [REG_AW-1:0] instr_2016,
    input  logic [REG_AW-1:0] instr_1511,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              alusrc,
    input  logic              regdst,
    output logic              out_valid,
    output logic [1:0]        ctlwb_out,
    output logic [1:0]        ctlm_out,
    output logic [DATA_W-1:0] adder_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic              zero_out,
    output logic [DATA_W-1:0] rdata2_out,
    output logic [REG_AW-1:0] muxout_out,
    output logic              stall_out
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam int         CW      = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [2*DATA_W-1:0]   prod, prod_nxt;
    logic [DATA_W-1:0]     mcand, mcand_nxt;
    logic                  neg, neg_nxt;
    logic [DATA_W-1:0]     hi, hi_nxt, lo, lo_nxt;

    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     result;
    logic                  is_mul, mul_signed;
    logic                  accept;
    logic [DATA_W-1:0]     abs_a, abs_b;
    logic [DATA_W:0]       step_sum;
    logic [2*DATA_W-1:0]   step_prod;
    logic [2*DATA_W-1:0]   final_prod;

    assign op_b      = alusrc ? s_extend : rdata2;
    assign stall_out = (state == MUL) | mem_stall;
    assign accept    = in_valid & ~stall_out & ~flush;

    always_comb begin
        result     = '0;
        is_mul     = 1'b0;
        mul_signed = 1'b0;
        case (alu_op)
            2'b00: result = rdata1 + op_b;
            2'b01: result = rdata1 - op_b;
            2'b10: begin
                case (funct)
                    F_ADD:   result = rdata1 + op_b;
                    F_SUB:   result = rdata1 - op_b;
                    F_AND:   result = rdata1 & op_b;
                    F_OR:    result = rdata1 | op_b;
                    F_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(rdata1) < $signed(op_b))};
                    F_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
                    F_MULTU: is_mul = 1'b1;
                    F_MFHI:  result = hi;
                    F_MFLO:  result = lo;
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    // Signed multiply runs unsigned on magnitudes; the sign is reapplied on the final step.
    assign abs_a      = (mul_signed && rdata1[DATA_W-1]) ? -rdata1 : rdata1;
    assign abs_b      = (mul_signed && op_b[DATA_W-1])   ? -op_b   : op_b;
    assign step_sum   = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
    assign step_prod  = {step_sum, prod[DATA_W-1:1]};
    assign final_prod = neg ? -step_prod : step_prod;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        prod_nxt  = prod;
        mcand_nxt = mcand;
        neg_nxt   = neg;
        hi_nxt    = hi;
        lo_nxt    = lo;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state_nxt = MUL;
                        cnt_nxt   = CW'(DATA_W);
                        mcand_nxt = abs_a;
                        prod_nxt  = {{DATA_W{1'b0}}, abs_b};
                        neg_nxt   = mul_signed & (rdata1[DATA_W-1] ^ op_b[DATA_W-1]);
                    end
                end
                MUL: begin
                    prod_nxt = step_prod;
                    cnt_nxt  = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        {hi_nxt, lo_nxt} = final_prod;
                        state_nxt        = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            prod  <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            prod  <= prod_nxt;
            mcand <= mcand_nxt;
            neg   <= neg_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    // EX/MEM register: flush beats mem_stall hold, which beats a new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            ctlwb_out      <= '0;
            ctlm_out       <= '0;
            adder_out      <= '0;
            alu_result_out <= '0;
            zero_out       <= 1'b0;
            rdata2_out     <= '0;
            muxout_out     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctlwb_out <= '0;
            ctlm_out  <= '0;
        end else if (mem_stall) begin
            out_valid <= out_valid;
        end else if (accept) begin
            out_valid      <= 1'b1;
            ctlwb_out      <= is_mul ? 2'b00 : ctlwb_in;
            ctlm_out       <= is_mul ? 2'b00 : ctlm_in;
            adder_out      <= npc + (s_extend << BR_SHIFT);
            alu_result_out <= result;
            zero_out       <= (result == '0);
            rdata2_out     <= rdata2;
            muxout_out     <= regdst ? instr_1511 : instr_2016;
        end else begin
            out_valid <= 1'b0;
            ctlwb_out <= '0;
            ctlm_out  <= '0;
        end
    end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Scoreboard bench for execute_stage_mc: directed vectors push expected EX/MEM contents,
// a negedge monitor pops and compares each freshly loaded entry.
module tb_execute_stage_mc;
    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, mem_stall = 1'b0, flush = 1'b0;
    logic [1:0]    ctlwb_in = '0, ctlm_in = '0, alu_op = '0;
    logic [W-1:0]  npc = '0, rdata1 = '0, rdata2 = '0, s_extend = '0;
    logic [AW-1:0] instr_2016 = '0, instr_1511 = '0;
    logic [5:0]    funct = '0;
    logic          alusrc = 1'b0, regdst = 1'b0;
    logic          out_valid, zero_out, stall_out;
    logic [1:0]    ctlwb_out, ctlm_out;
    logic [W-1:0]  adder_out, alu_result_out, rdata2_out;
    logic [AW-1:0] muxout_out;

    always #5 clk = ~clk;

    execute_stage_mc #(.DATA_W(W), .REG_AW(AW), .BR_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_stall(mem_stall), .flush(flush),
        .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
        .s_extend(s_extend), .instr_2016(instr_2016), .instr_1511(instr_1511), .alu_op(alu_op),
        .funct(funct), .alusrc(alusrc), .regdst(regdst), .out_valid(out_valid),
        .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .adder_out(adder_out),
        .alu_result_out(alu_result_out), .zero_out(zero_out), .rdata2_out(rdata2_out),
        .muxout_out(muxout_out), .stall_out(stall_out)
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [W-1:0]  add;
        logic [AW-1:0] dst;
        logic [1:0]    wb;
        logic [1:0]    m;
        logic [W-1:0]  st;
        bit            chk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic ms_prev = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && !ms_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", alu_result_out);
            end else begin
                e = sb.pop_front();
                chk("sb_wb", {30'd0, ctlwb_out}, {30'd0, e.wb});
                chk("sb_m", {30'd0, ctlm_out}, {30'd0, e.m});
                if (e.chk) begin
                    chk("sb_result", alu_result_out, e.res);
                    chk("sb_zero", {31'd0, zero_out}, {31'd0, (e.res == '0)});
                    chk("sb_adder", adder_out, e.add);
                    chk("sb_dest", {27'd0, muxout_out}, {27'd0, e.dst});
                    chk("sb_store", rdata2_out, e.st);
                end
            end
        end
        ms_prev = mem_stall;
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a, b, imm, pc,
                         input logic asrc, rdst, input logic [AW-1:0] rt, rd,
                         input logic [W-1:0] e_res, e_add, input logic [AW-1:0] e_dst, input bit is_mul);
        exp_t e;
        alu_op = op; funct = fn; rdata1 = a; rdata2 = b; s_extend = imm; npc = pc;
        alusrc = asrc; regdst = rdst; instr_2016 = rt; instr_1511 = rd;
        ctlwb_in = 2'b10; ctlm_in = 2'b01; in_valid = 1'b1;
        e.res = e_res; e.add = e_add; e.dst = e_dst; e.st = b; e.chk = !is_mul;
        e.wb  = is_mul ? 2'b00 : 2'b10;
        e.m   = is_mul ? 2'b00 : 2'b01;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // R-type helper: npc=0x400, imm=0x10 gives adder 0x440; dest is rd=9.
    task automatic rtype(input logic [5:0] fn, input logic [W-1:0] a, b, e_res);
        issue(2'b10, fn, a, b, 32'h10, 32'h400, 1'b0, 1'b1, 5'd3, 5'd9, e_res, 32'h440, 5'd9,
              (fn == 6'b011000) || (fn == 6'b011001));
    endtask

    task automatic count_stall(input int ms_on, input int ms_off, output int n);
        n = 0;
        while (stall_out === 1'b1 && n < 100) begin
            n++;
            if (n == ms_on)  mem_stall = 1'b1;
            if (n == ms_off) mem_stall = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", alu_result_out, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // add with regdst=1, then hold through three mem_stall cycles
        issue(2'b10, 6'b100000, 32'd10, 32'd20, 32'd4, 32'd100, 1'b0, 1'b1, 5'd5, 5'd10, 32'd30, 32'd116, 5'd10, 0);
        mem_stall = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_result", alu_result_out, 32'd30);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
        end
        mem_stall = 1'b0;
        @(posedge clk); #1;
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_wb", {30'd0, ctlwb_out}, 32'd0);

        // alu_op add/sub paths, reserved op, logic and slt
        issue(2'b00, 6'b000000, 32'd10, 32'd99, 32'd4, 32'd200, 1'b1, 1'b0, 5'd5, 5'd10, 32'd14, 32'd216, 5'd5, 0);
        issue(2'b01, 6'b000000, 32'd7, 32'd7, 32'd4, 32'd200, 1'b0, 1'b0, 5'd5, 5'd10, 32'd0, 32'd216, 5'd5, 0);
        issue(2'b01, 6'b000000, 32'd10, 32'd20, 32'd4, 32'd200, 1'b0, 1'b0, 5'd5, 5'd10, 32'hFFFF_FFF6, 32'd216, 5'd5, 0);
        issue(2'b11, 6'b100000, 32'd5, 32'd3, 32'd4, 32'd200, 1'b0, 1'b0, 5'd5, 5'd10, 32'd0, 32'd216, 5'd5, 0);
        rtype(6'b111111, 32'd5, 32'd3, 32'd0);
        rtype(6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        rtype(6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        rtype(6'b100010, 32'd3, 32'd5, 32'hFFFF_FFFE);
        rtype(6'b101010, 32'd3, 32'd5, 32'd1);
        rtype(6'b101010, 32'd5, 32'd3, 32'd0);

        // flush blocks an incoming instruction; flush beats mem_stall on a valid entry
        rtype(6'b100000, 32'd1, 32'd1, 32'd2);
        mem_stall = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        mem_stall = 1'b0;
        chk("flush_stall_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_stall_wb", {30'd0, ctlwb_out}, 32'd0);
        alu_op = 2'b10; funct = 6'b100000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_in_valid", {31'd0, out_valid}, 32'd0);

        // MULT -7 x 3
        rtype(6'b011000, 32'hFFFF_FFF9, 32'd3, 32'd0);
        count_stall(-1, -1, n);
        chk("mult_stall_cycles", n, 32'd32);
        rtype(6'b010010, 32'd0, 32'd0, 32'hFFFF_FFEB);
        rtype(6'b010000, 32'd0, 32'd0, 32'hFFFF_FFFF);

        // MULTU 0xFFFFFFFF x 2 with mem_stall pulsed mid-multiply
        rtype(6'b011001, 32'hFFFF_FFFF, 32'd2, 32'd0);
        count_stall(5, 8, n);
        mem_stall = 1'b0;
        chk("multu_stall_cycles", n, 32'd32);
        rtype(6'b010000, 32'd0, 32'd0, 32'd1);
        rtype(6'b010010, 32'd0, 32'd0, 32'hFFFF_FFFE);
        rtype(6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1);

        // flush mid-multiply leaves HI/LO alone
        rtype(6'b011000, 32'd5, 32'd5, 32'd0);
        repeat (9) begin @(posedge clk); #1; end
        chk("mul_busy", {31'd0, stall_out}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_mul_stall", {31'd0, stall_out}, 32'd0);
        rtype(6'b010000, 32'd0, 32'd0, 32'd1);
        rtype(6'b010010, 32'd0, 32'd0, 32'hFFFF_FFFE);

        // async reset mid-multiply
        rtype(6'b011000, 32'd9, 32'd9, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_stall", {31'd0, stall_out}, 32'd0);
        chk("rstmid_adder", adder_out, 32'd0);
        chk("rstmid_store", rdata2_out, 32'd0);
        chk("rstmid_dest", {27'd0, muxout_out}, 32'd0);
        chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rtype(6'b010000, 32'd0, 32'd0, 32'd0);
        rtype(6'b010010, 32'd0, 32'd0, 32'd0);

        repeat (3) begin @(posedge clk); #1; end
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
